// File: rtl/hasti_sram_slave.sv
// -----------------------------------------------------------------------------
// hasti_sram_slave
//   AHB-Lite (Hasti) responder backing one decoded slave region with an
//   on-chip, word-organised memory built from four byte-lane arrays.
//   Byte / halfword / word accesses, byte-lane write enables, WAIT_STATES
//   data-phase wait cycles per OKAY transfer, two-cycle ERROR response for
//   unaligned or oversize accesses.
//
// Parameters
//   ADDR_W       word-address bits (depth = 2**ADDR_W 32-bit words)
//   WAIT_STATES  wait cycles per OKAY data phase, 0..3
//
// Ports
//   clk, reset_n         clock (rising edge), async active-low reset
//   io_hsel              slave select from the interconnect decoder
//   io_haddr, io_hwrite, io_hsize, io_htrans   address-phase controls
//   io_hburst, io_hprot, io_hmastlock          accepted but ignored
//   io_hwdata            write data (data phase)
//   io_hreadyin          bus-level HREADY
//   io_hrdata            read data (0 outside read data phases)
//   io_hreadyout         slave ready
//   io_hresp             0 OKAY, 1 ERROR
// -----------------------------------------------------------------------------

// One byte lane of the memory: synchronous write, combinational read.
module hasti_sram_lane #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] idx,
    input  logic [7:0]        wdata,
    output logic [7:0]        rdata
);
    logic [7:0] mem [2**ADDR_W];

    // Contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (we) mem[idx] <= wdata;
    end

    assign rdata = mem[idx];
endmodule

module hasti_sram_slave #(
    parameter int ADDR_W      = 10,
    parameter int WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        io_hsel,
    input  logic [31:0] io_haddr,
    input  logic        io_hwrite,
    input  logic [2:0]  io_hsize,
    input  logic [2:0]  io_hburst,
    input  logic [3:0]  io_hprot,
    input  logic [1:0]  io_htrans,
    input  logic        io_hmastlock,
    input  logic [31:0] io_hwdata,
    input  logic        io_hreadyin,
    output logic [31:0] io_hrdata,
    output logic        io_hreadyout,
    output logic        io_hresp
);
    localparam int         NUM_LANES = 4;
    localparam int         LANE_W    = 8;
    localparam logic [1:0] WS_LOAD   = (WAIT_STATES > 0) ? 2'(WAIT_STATES - 1) : 2'd0;

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;

    state_t                               state_q, state_d;
    logic [1:0]                           cnt_q, cnt_d;
    logic [ADDR_W-1:0]                    idx_q;
    logic [NUM_LANES-1:0]                 mask_q, mask_a;
    logic                                 wr_q;
    logic                                 err_a;
    logic                                 ready_st;
    logic                                 valid;
    logic                                 commit;
    logic                                 rd_en;
    logic [NUM_LANES-1:0]                 lane_we;
    logic [NUM_LANES-1:0][LANE_W-1:0]     lane_wdata;
    logic [NUM_LANES-1:0][LANE_W-1:0]     lane_rdata;
    logic                                 unused_ok;

    assign unused_ok = &{1'b0, io_hburst, io_hprot, io_hmastlock, io_htrans[0],
                         io_haddr[31:ADDR_W+2]};

    // The address phase is only looked at while we drive hreadyout=1;
    // during WAIT/ERR1 the bus is stalled by us and must not be sampled.
    assign ready_st = (state_q == S_IDLE) || (state_q == S_DATA) || (state_q == S_ERR2);
    assign valid    = ready_st & io_hsel & io_hreadyin & io_htrans[1];

    // Address-phase decode: lane mask and alignment/size error.
    always_comb begin
        mask_a = 4'hF;
        case (io_hsize)
            3'd0:    mask_a = 4'b0001 << io_haddr[1:0];
            3'd1:    mask_a = io_haddr[1] ? 4'b1100 : 4'b0011;
            default: mask_a = 4'hF;
        endcase
        err_a = (io_hsize > 3'd2)
              | ((io_hsize == 3'd1) & io_haddr[0])
              | ((io_hsize == 3'd2) & (|io_haddr[1:0]));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 2'd0;
            idx_q   <= '0;
            mask_q  <= '0;
            wr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (valid) begin
                idx_q  <= io_haddr[ADDR_W+1:2];
                mask_q <= mask_a;
                wr_q   <= io_hwrite;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        io_hreadyout = 1'b1;
        io_hresp     = 1'b0;
        case (state_q)
            S_WAIT: begin
                io_hreadyout = 1'b0;
                if (cnt_q == 2'd0) state_d = S_DATA;
                else               cnt_d   = cnt_q - 2'd1;
            end
            S_ERR1: begin
                io_hreadyout = 1'b0;
                io_hresp     = 1'b1;
                state_d      = S_ERR2;
            end
            default: begin
                // IDLE, DATA, ERR2: the bus can hand us the next transfer.
                io_hresp = (state_q == S_ERR2);
                if (valid && err_a) begin
                    state_d = S_ERR1;
                end else if (valid) begin
                    if (WAIT_STATES > 0) begin
                        state_d = S_WAIT;
                        cnt_d   = WS_LOAD;
                    end else begin
                        state_d = S_DATA;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    // A write commits on the edge that ends DATA, which is also the edge a
    // following read's data phase starts on, so that read sees the new data.
    assign commit     = (state_q == S_DATA) & wr_q;
    assign lane_we    = {NUM_LANES{commit}} & mask_q;
    assign lane_wdata = io_hwdata;

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        hasti_sram_lane #(.ADDR_W(ADDR_W)) u_lane (
            .clk   (clk),
            .we    (lane_we[l]),
            .idx   (idx_q),
            .wdata (lane_wdata[l]),
            .rdata (lane_rdata[l])
        );
    end

    assign rd_en     = ((state_q == S_WAIT) || (state_q == S_DATA)) & ~wr_q;
    assign io_hrdata = rd_en ? lane_rdata : 32'd0;
endmodule

// File: doc/hasti_sram_slave.md
Name: hasti_sram_slave

Overview:
- AHB-Lite (Hasti) responder that backs one decoded slave region with an on-chip word-organised memory.
- Connects to one slave port of the Hasti bus interconnect (the `io_slaves_N_*` signal group).
- Supports byte, halfword and word accesses with byte-lane write enables and configurable wait states.
- Unaligned or oversize accesses get the two-cycle AHB ERROR response.

Parameters:
ADDR_W, 10, word-address bits; memory depth = 2^ADDR_W 32-bit words (4 KiB default); region offset = haddr[ADDR_W+1:0]
WAIT_STATES, 0, data-phase wait cycles per OKAY transfer, legal range 0..3

Ports:
clk  input  1  clock, all state on rising edge
reset_n  input  1  asynchronous active-low reset
io_hsel  input  1  slave select from interconnect decoder
io_haddr  input  32  address (address phase)
io_hwrite  input  1  1 = write
io_hsize  input  3  0 byte, 1 halfword, 2 word, >2 illegal
io_hburst  input  3  ignored
io_hprot  input  4  ignored
io_htrans  input  2  0 IDLE, 1 BUSY, 2 NONSEQ, 3 SEQ
io_hmastlock  input  1  ignored
io_hwdata  input  32  write data (data phase)
io_hreadyin  input  1  bus-level HREADY; address phase sampled only when 1
io_hrdata  output  32  read data
io_hreadyout  output  1  slave ready
io_hresp  output  1  0 OKAY, 1 ERROR

Behaviour:
- Valid address phase: rising edge with hsel & hreadyin & htrans[1]. Any other combination leaves no data phase pending.
- On a valid address phase, latch:
  - word index haddr[ADDR_W+1:2]
  - byte lane mask
  - hwrite
  - error flag
- Lane mask:
  - size 0: bit haddr[1:0]
  - size 1: bits {2*haddr[1]+1, 2*haddr[1]}
  - size 2: 4'hF
- Error when any of:
  - hsize > 2
  - size 1 with haddr[0] = 1
  - size 2 with haddr[1:0] != 0
- States:
  - IDLE: hreadyout=1, hresp=0.
  - WAIT: hreadyout=0, hresp=0, counter counts down.
  - DATA: hreadyout=1, hresp=0, transfer completes.
  - ERR1: hreadyout=0, hresp=1.
  - ERR2: hreadyout=1, hresp=1.
- Next state, evaluated only in states with hreadyout=1 (IDLE/DATA/ERR2):
  - valid & error → ERR1
  - valid & ok & WAIT_STATES>0 → WAIT (counter=WAIT_STATES-1)
  - valid & ok & WAIT_STATES=0 → DATA
  - otherwise → IDLE
- Other transitions:
  - WAIT: counter=0 → DATA, else decrement.
  - ERR1 → ERR2, always.
- Address phase in WAIT/ERR1: ignored (hreadyin is 0 then in a legal system; the slave must not sample it).
- Data phase length: OKAY = 1+WAIT_STATES cycles; ERROR = exactly 2 cycles.
- Write commit: on the rising edge ending DATA with latched hwrite=1, write hwdata byte lanes per mask into mem[index]. Unmasked bytes keep their value.
- Errored transfers never modify memory.
- Read data: in WAIT/DATA with latched hwrite=0, hrdata = mem[index] (full word, combinational from array). In all other states hrdata=0.
- Pipelining:
  - A read whose address phase coincides with a write's DATA cycle sees the written data, because the write commits at the edge where the read's data phase begins.
  - Back-to-back transfers run with no idle cycle when WAIT_STATES=0.
- Reset assertion (any time, including mid-WAIT or ERR1): immediately go to IDLE with hreadyout=1, hresp=0, hrdata=0, counter=0. Memory contents are not reset.
- Output reset values: io_hrdata=0, io_hreadyout=1, io_hresp=0.

Test Plan:
1. Reset → reset_n=0: hreadyout=1, hresp=0, hrdata=0. Release, drive 4 idle cycles with hsel=1, htrans=IDLE → hreadyout stays 1, no memory change.
2. WAIT_STATES=0 → word write 0xDEADBEEF @0x10 followed by word read @0x10, back-to-back: no stall cycles, read data phase hrdata=0xDEADBEEF, hresp=0.
3. Sub-word writes → continuing from test 2: byte 0x11 @0x13 (hwdata=0x11000000), then halfword 0x2233 @0x10 (hwdata=0x00002233), then word read @0x10 → hrdata=0x11AD2233.
4. Error responses → word read @0x02: cycle1 hreadyout=0/hresp=1, cycle2 hreadyout=1/hresp=1. Word write @0x11 with hsize=3: same two-cycle ERROR, and a subsequent read @0x10 still returns 0x11AD2233.
5. WAIT_STATES=2 → write 0xCAFEF00D @0x4 then read @0x4 pipelined: each data phase shows 2 cycles hreadyout=0 then 1; read returns 0xCAFEF00D. Drive htrans=NONSEQ, hsel=1, hreadyin=0 during the wait cycles with a different address: ignored, no extra data phase.
6. Reset mid-operation → WAIT_STATES=3 write @0x8 (0x12345678), reset_n=0 during second wait cycle: hreadyout=1 asynchronously, state IDLE. After release, read @0x8 returns its prior contents (write not committed).
